// File: rtl/rede_pkg.sv
// rede_pkg -- shared constants and types for the single-neuron core.
//   DATA_W : width of samples and results (signed)
//   WGT_W  : width of the Q1.14 weights (signed)
//   FRAC   : fractional bits of the weights, removed by the final shift
//   ACC_W  : accumulator width, wide enough for four full-scale products
//   PORT_* : one-hot port codes used on req_in / out_en
//   state_t: sequencer states
package rede_pkg;

  localparam int DATA_W = 31;
  localparam int WGT_W  = 16;
  localparam int FRAC   = 14;
  localparam int ACC_W  = 50;

  localparam logic [3:0] PORT_NONE = 4'b0000;
  localparam logic [3:0] PORT_0    = 4'b0001;
  localparam logic [3:0] PORT_1    = 4'b0010;
  localparam logic [3:0] PORT_2    = 4'b0100;
  localparam logic [3:0] PORT_3    = 4'b1000;

  // ST_IDLE is only occupied while reset is held: it is the "RD0 pending"
  // state, so the first edge after release enters RD0 with req_in=0001.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_RD3,
    ST_ACT,
    ST_OUT
  } state_t;

  // Input-port request presented while the sequencer sits in state s.
  function automatic logic [3:0] req_code(input state_t s);
    logic [3:0] code;
    code = PORT_NONE;
    case (s)
      ST_RD0:  code = PORT_0;
      ST_RD1:  code = PORT_1;
      ST_RD2:  code = PORT_2;
      ST_RD3:  code = PORT_3;
      default: code = PORT_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rede_act.sv
// rede_act -- activation stage (purely combinational).
// Takes the full-width weighted sum, removes the Q1.14 fraction with a
// floor (arithmetic) shift, adds the bias at full width, saturates to the
// signed DATA_W range and finally applies ReLU.
//   i_acc : signed accumulator, ACC_W bits
//   o_y   : non-negative result, DATA_W bits
module rede_act
  import rede_pkg::*;
#(
  parameter logic signed [DATA_W-1:0] BIAS = '0
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DATA_W-1:0] o_y
);

  // One extra bit so the bias add can never wrap.
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    SUM_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - SUM_W'(1);

  logic signed [ACC_W-1:0]  w_shift;
  logic signed [SUM_W-1:0]  w_shift_ext;
  logic signed [SUM_W-1:0]  w_bias_ext;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] w_sat;

  assign w_shift     = i_acc >>> FRAC;
  assign w_shift_ext = {w_shift[ACC_W-1], w_shift};
  assign w_bias_ext  = {{(SUM_W - DATA_W){BIAS[DATA_W-1]}}, BIAS};
  assign w_sum       = w_shift_ext + w_bias_ext;

  always_comb begin
    w_sat = w_sum[DATA_W-1:0];
    if (w_sum > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_W-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_W-1:0];
    end
  end

  assign o_y = w_sat[DATA_W-1] ? '0 : w_sat;

endmodule

// File: rtl/rede_core.sv
// rede_core -- single-neuron engine.
// Reads four samples from input ports 0..3 over four cycles, forms
// y = ReLU(sat(((W0*x0 + W1*x1 + W2*x2 + W3*x3) >>> 14) + BIAS)) and
// presents it on output port 0. One result every 6 cycles.
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active low
//   io_in  : signed sample, sampled at the end of each read cycle
//   io_out : registered result, held until the next OUT state
//   req_in : registered one-hot input-port request
//   out_en : registered output-port enable, 0001 in the OUT state only
module rede_core
  import rede_pkg::*;
#(
  parameter logic signed [WGT_W-1:0]  W0   = 16'sd16384,
  parameter logic signed [WGT_W-1:0]  W1   = 16'sd8192,
  parameter logic signed [WGT_W-1:0]  W2   = -16'sd16384,
  parameter logic signed [WGT_W-1:0]  W3   = 16'sd0,
  parameter logic signed [DATA_W-1:0] BIAS = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] io_in,
  output logic signed [DATA_W-1:0] io_out,
  output logic        [3:0]        req_in,
  output logic        [3:0]        out_en
);

  state_t                   r_state;
  state_t                   w_state_next;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_io_out;
  logic        [3:0]        r_req;
  logic        [3:0]        r_out_en;

  logic signed [WGT_W-1:0]  w_wgt;
  logic signed [ACC_W-1:0]  w_wgt_ext;
  logic signed [ACC_W-1:0]  w_x_ext;
  logic signed [ACC_W-1:0]  w_prod;
  logic signed [DATA_W-1:0] w_act;

  // Next state and the weight belonging to the port being read now.
  always_comb begin
    w_state_next = r_state;
    w_wgt        = '0;
    case (r_state)
      ST_IDLE: w_state_next = ST_RD0;
      ST_RD0: begin
        w_state_next = ST_RD1;
        w_wgt        = W0;
      end
      ST_RD1: begin
        w_state_next = ST_RD2;
        w_wgt        = W1;
      end
      ST_RD2: begin
        w_state_next = ST_RD3;
        w_wgt        = W2;
      end
      ST_RD3: begin
        w_state_next = ST_ACT;
        w_wgt        = W3;
      end
      ST_ACT:  w_state_next = ST_OUT;
      ST_OUT:  w_state_next = ST_RD0;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Both operands widened to the accumulator width so the product is exact.
  assign w_wgt_ext = {{(ACC_W - WGT_W){w_wgt[WGT_W-1]}}, w_wgt};
  assign w_x_ext   = {{(ACC_W - DATA_W){io_in[DATA_W-1]}}, io_in};
  assign w_prod    = w_wgt_ext * w_x_ext;

  rede_act #(
    .BIAS (BIAS)
  ) u_act (
    .i_acc (r_acc),
    .o_y   (w_act)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_io_out <= '0;
      r_req    <= PORT_NONE;
      r_out_en <= PORT_NONE;
    end else begin
      r_state <= w_state_next;
      // Outputs are registered from the next state so they line up with it.
      r_req    <= req_code(w_state_next);
      r_out_en <= (w_state_next == ST_OUT) ? PORT_0 : PORT_NONE;
      case (r_state)
        ST_RD0:                 r_acc <= w_prod;
        ST_RD1, ST_RD2, ST_RD3: r_acc <= r_acc + w_prod;
        default:                r_acc <= r_acc;
      endcase
      // The accumulator is complete during ACT; the result lands as OUT starts.
      if (r_state == ST_ACT) begin
        r_io_out <= w_act;
      end
    end
  end

  assign io_out = r_io_out;
  assign req_in = r_req;
  assign out_en = r_out_en;

endmodule

// File: tb/tb_rede_core.sv
// tb_rede_core -- directed self-checking bench for rede_core.
// u_dut runs with default weights; u_dut2 uses W0=1, others 0, BIAS=-1
// to exercise the floor shift and bias path. Both share clk/rst/io_in.
module tb_rede_core;

  logic               clk;
  logic               rst;
  logic signed [30:0] io_in;
  logic signed [30:0] io_out;
  logic        [3:0]  req_in;
  logic        [3:0]  out_en;
  logic signed [30:0] io_out2;
  logic        [3:0]  req_in2;
  logic        [3:0]  out_en2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rede_core u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_in  (io_in),
    .io_out (io_out),
    .req_in (req_in),
    .out_en (out_en)
  );

  rede_core #(
    .W0   (16'sd1),
    .W1   (16'sd0),
    .W2   (16'sd0),
    .W3   (16'sd0),
    .BIAS (-31'sd1)
  ) u_dut2 (
    .clk    (clk),
    .rst    (rst),
    .io_in  (io_in),
    .io_out (io_out2),
    .req_in (req_in2),
    .out_en (out_en2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [30:0] x0;
    logic signed [30:0] x1;
    logic signed [30:0] x2;
    logic signed [30:0] x3;
    logic signed [30:0] exp1;
    logic signed [30:0] exp2;
  } vec_t;

  // Waits (bounded) for req_in=0001, feeds x0..x3 in RD0..RD3 and samples
  // both DUTs in the OUT cycle. waits = negedges spent finding RD0 (0 = never).
  task automatic drive_sample(input logic signed [30:0] x0, input logic signed [30:0] x1,
                              input logic signed [30:0] x2, input logic signed [30:0] x3,
                              output logic signed [30:0] y, output logic [3:0] en,
                              output logic signed [30:0] y2, output logic [3:0] en2,
                              output int waits);
    bit synced;
    synced = 1'b0;
    waits  = 0;
    y = '0; en = '0; y2 = '0; en2 = '0;
    for (int i = 1; i <= 12 && !synced; i++) begin
      @(negedge clk);
      if (req_in == 4'b0001) begin
        synced = 1'b1;
        waits  = i;
      end
    end
    if (synced) begin
      io_in = x0;
      @(negedge clk) io_in = x1;
      @(negedge clk) io_in = x2;
      @(negedge clk) io_in = x3;
      @(negedge clk) io_in = '0;   // ACT
      @(negedge clk);              // OUT
      y   = io_out;
      en  = out_en;
      y2  = io_out2;
      en2 = out_en2;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b0;
    io_in = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (req_in !== 4'b0000) $display("FAIL reset_req_in: got %b want 0000", req_in);
    else pass_cnt++;
    total_cnt++;
    if (out_en !== 4'b0000) $display("FAIL reset_out_en: got %b want 0000", out_en);
    else pass_cnt++;
    total_cnt++;
    if (io_out !== 31'sd0) $display("FAIL reset_io_out: got %0d want 0", io_out);
    else pass_cnt++;
    $display("reset: req_in=%b out_en=%b io_out=%0d", req_in, out_en, io_out);
  endtask

  task automatic test_sequence;
    logic [3:0] exp_req [6];
    logic [3:0] exp_en  [6];
    exp_req = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    exp_en  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    rst = 1'b1;   // released on a negedge; next edge enters RD0
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total_cnt++;
      if (req_in !== exp_req[c % 6])
        $display("FAIL seq_req_in[%0d]: got %b want %b", c, req_in, exp_req[c % 6]);
      else pass_cnt++;
      total_cnt++;
      if (out_en !== exp_en[c % 6])
        $display("FAIL seq_out_en[%0d]: got %b want %b", c, out_en, exp_en[c % 6]);
      else pass_cnt++;
      $display("seq cycle %0d: req_in=%b out_en=%b", c, req_in, out_en);
    end
  endtask

  task automatic test_vectors;
    vec_t v [9];
    logic signed [30:0] y, y2;
    logic [3:0] en, en2;
    int waits;
    v = '{
      '{100, 200, 50, 7, 150, 0},
      '{0, 0, 100, 0, 0, 0},
      '{1073741823, 1073741823, 0, 0, 1073741823, 65534},
      '{3, 0, 0, 0, 3, 0},
      '{3, -1, 0, 0, 2, 0},
      '{0, 0, -300, 0, 300, 0},
      '{49152, 0, 0, 0, 49152, 2},
      '{0, 0, 0, 123456, 0, 0},
      '{0, -1073741824, -1073741824, 0, 536870912, 0}
    };
    for (int n = 0; n < 9; n++) begin
      drive_sample(v[n].x0, v[n].x1, v[n].x2, v[n].x3, y, en, y2, en2, waits);
      total_cnt++;
      if (waits == 0) $display("FAIL vec%0d_sync: got no req_in=0001 within 12 cycles", n);
      else pass_cnt++;
      total_cnt++;
      if (en !== 4'b0001) $display("FAIL vec%0d_out_en: got %b want 0001", n, en);
      else pass_cnt++;
      total_cnt++;
      if (y !== v[n].exp1) $display("FAIL vec%0d_io_out: got %0d want %0d", n, y, v[n].exp1);
      else pass_cnt++;
      total_cnt++;
      if (y2 !== v[n].exp2) $display("FAIL vec%0d_io_out_bias: got %0d want %0d", n, y2, v[n].exp2);
      else pass_cnt++;
      $display("vec%0d x=(%0d,%0d,%0d,%0d) io_out=%0d out_en=%b io_out_bias=%0d",
               n, v[n].x0, v[n].x1, v[n].x2, v[n].x3, y, en, y2);
    end
  endtask

  // Result must persist after OUT while out_en drops and RD0 begins.
  task automatic test_hold;
    logic signed [30:0] y, y2;
    logic [3:0] en, en2;
    int waits;
    drive_sample(100, 200, 50, 7, y, en, y2, en2, waits);
    @(negedge clk);
    total_cnt++;
    if (io_out !== 31'sd150) $display("FAIL hold_io_out: got %0d want 150", io_out);
    else pass_cnt++;
    total_cnt++;
    if (out_en !== 4'b0000) $display("FAIL hold_out_en: got %b want 0000", out_en);
    else pass_cnt++;
    total_cnt++;
    if (req_in !== 4'b0001) $display("FAIL hold_req_in: got %b want 0001", req_in);
    else pass_cnt++;
    $display("hold: io_out=%0d out_en=%b req_in=%b", io_out, out_en, req_in);
  endtask

  task automatic test_reset_mid;
    logic signed [30:0] y, y2;
    logic [3:0] en, en2;
    int waits;
    bit synced;
    synced = 1'b0;
    // Now in RD0 of a sequence whose io_out still holds 150.
    io_in = 31'sd1000;
    @(negedge clk) io_in = 31'sd1000;
    @(negedge clk);
    total_cnt++;
    if (req_in !== 4'b0100) $display("FAIL mid_in_rd2: got %b want 0100", req_in);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (req_in !== 4'b0000) $display("FAIL mid_rst_req_in: got %b want 0000", req_in);
    else pass_cnt++;
    total_cnt++;
    if (out_en !== 4'b0000) $display("FAIL mid_rst_out_en: got %b want 0000", out_en);
    else pass_cnt++;
    total_cnt++;
    if (io_out !== 31'sd0) $display("FAIL mid_rst_io_out: got %0d want 0", io_out);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    drive_sample(10, 20, 0, 0, y, en, y2, en2, waits);
    total_cnt++;
    if (waits != 1) $display("FAIL mid_restart_rd0: got req_in=0001 after %0d cycles want 1", waits);
    else pass_cnt++;
    total_cnt++;
    if (en !== 4'b0001) $display("FAIL mid_out_en: got %b want 0001", en);
    else pass_cnt++;
    total_cnt++;
    if (y !== 31'sd20) $display("FAIL mid_io_out: got %0d want 20", y);
    else pass_cnt++;
    $display("reset mid-sequence: restart after %0d cycles io_out=%0d out_en=%b", waits, y, en);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_vectors();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
